// File: rtl/protocol_pkg.sv
// Shared definitions for the protocol receiver: word type codes, register map,
// STATUS bit positions, deframer states and the running checksum helper.
package protocol_pkg;

  localparam int PAYLOAD_W = 24;
  localparam int FCNT_W    = 16;

  localparam logic [1:0] TYPE_RSV = 2'b00;
  localparam logic [1:0] TYPE_HDR = 2'b01;
  localparam logic [1:0] TYPE_DAT = 2'b10;
  localparam logic [1:0] TYPE_TRL = 2'b11;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_CKSUM = 3;
  localparam int ST_FRAME = 4;
  localparam int ST_BUSY  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2
  } rx_state_e;

  // Frame checksum is the payload sum modulo 2^24
  function automatic logic [PAYLOAD_W-1:0] csum_add(input logic [PAYLOAD_W-1:0] a,
                                                    input logic [PAYLOAD_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/protocol_rx_fifo.sv
// Synchronous FIFO for received payload words; DEPTH must be a power of two.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module protocol_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [LVL_W-1:0] cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (cnt_r == LVL_W'(DEPTH));
  assign empty     = (cnt_r == {LVL_W{1'b0}});
  assign level     = cnt_r;
  assign head      = mem_r[rptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage array write port
  always_ff @(posedge clock) begin
    if (do_push_s && !clear) begin
      mem_r[wptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_r <= {AW{1'b0}};
      rptr_r <= {AW{1'b0}};
      cnt_r  <= {LVL_W{1'b0}};
    end else if (clear) begin
      wptr_r <= {AW{1'b0}};
      rptr_r <= {AW{1'b0}};
      cnt_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + AW'(1);
      if (do_pop_s)  rptr_r <= rptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + LVL_W'(1);
        2'b01:   cnt_r <= cnt_r - LVL_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/protocol_receiver_interface.sv
// Avalon-MM receive peripheral: deframes toggle-strobed protocol words, checks the
// frame checksum and queues payload for the CPU. Optional irq under PROTO_RX_IRQ_EN.
module protocol_receiver_interface
  import protocol_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic [31:0] data_import,
  output logic [31:0] data_export
`ifdef PROTO_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  rx_state_e             state_r;
  logic                  tog_r, new_r, enable_r;
  logic [31:0]           word_r, status_s, ctrl_rd_s, data_export_r;
  logic [7:0]            cnt_r;
  logic [PAYLOAD_W-1:0]  sum_r, payload_s, head_s;
  logic                  ovf_r, ck_r, fr_r;
  logic [FCNT_W-1:0]     frame_count_r;
  logic [LVL_W-1:0]      level_s;
  logic [1:0]            typ_s;
  logic                  act_s, pop_s, flush_s, sts_clr_s, full_s, empty_s;
  logic                  push_s, fr_set_s, ck_set_s, fc_inc_s, ovf_set_s;
  logic                  unused_s;

  assign typ_s     = word_r[30:29];
  assign payload_s = word_r[PAYLOAD_W-1:0];
  assign act_s     = new_r & enable_r;
  assign pop_s     = read & (address == ADDR_DATA) & ~empty_s;
  assign flush_s   = write & (address == ADDR_CTRL) & writedata[1];
  assign sts_clr_s = write & (address == ADDR_STATUS);
  assign ovf_set_s = push_s & full_s & ~pop_s;
  assign unused_s  = ^{writedata[31:5], word_r[28:24]};

  protocol_rx_fifo #(.DEPTH(DEPTH), .W(PAYLOAD_W), .LVL_W(LVL_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (payload_s),
    .head  (head_s),
    .level (level_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Word capture: the toggle register follows bit 31 every cycle, even when disabled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tog_r  <= 1'b0;
      new_r  <= 1'b0;
      word_r <= 32'h0;
    end else begin
      tog_r  <= data_import[31];
      new_r  <= data_import[31] ^ tog_r;
      word_r <= data_import;
    end
  end

  // Per-word event decode for the word captured last cycle
  always_comb begin
    push_s   = 1'b0;
    fr_set_s = 1'b0;
    ck_set_s = 1'b0;
    fc_inc_s = 1'b0;
    if (act_s) begin
      case (state_r)
        IDLE: fr_set_s = (typ_s == TYPE_DAT) || (typ_s == TYPE_TRL);
        DATA: begin
          push_s   = (typ_s == TYPE_DAT);
          fr_set_s = (typ_s == TYPE_HDR) || (typ_s == TYPE_TRL);
        end
        CHK: begin
          fr_set_s = (typ_s == TYPE_HDR) || (typ_s == TYPE_DAT);
          fc_inc_s = (typ_s == TYPE_TRL) && (payload_s == sum_r);
          ck_set_s = (typ_s == TYPE_TRL) && (payload_s != sum_r);
        end
        default: push_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Deframer FSM; a fresh header restarts the frame from IDLE or mid-DATA
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      sum_r   <= {PAYLOAD_W{1'b0}};
    end else if (flush_s) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      sum_r   <= {PAYLOAD_W{1'b0}};
    end else if (act_s) begin
      case (state_r)
        IDLE, DATA: begin
          if (typ_s == TYPE_HDR) begin
            state_r <= (word_r[7:0] == 8'd0) ? CHK : DATA;
            cnt_r   <= word_r[7:0];
            sum_r   <= {PAYLOAD_W{1'b0}};
          end else if ((typ_s == TYPE_DAT) && (state_r == DATA)) begin
            sum_r <= csum_add(sum_r, payload_s);
            cnt_r <= cnt_r - 8'd1;
            if (cnt_r == 8'd1) state_r <= CHK;
          end else if (typ_s == TYPE_TRL) begin
            state_r <= IDLE;
          end
        end
        CHK: if (typ_s != TYPE_RSV) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Sticky flags (set beats write-1-to-clear), frame counter, control, export mirror
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_r         <= 1'b0;
      ck_r          <= 1'b0;
      fr_r          <= 1'b0;
      frame_count_r <= {FCNT_W{1'b0}};
      enable_r      <= 1'b0;
      data_export_r <= 32'h0;
    end else begin
      ovf_r         <= ovf_set_s | (ovf_r & ~(sts_clr_s & writedata[ST_OVF]));
      ck_r          <= ck_set_s  | (ck_r  & ~(sts_clr_s & writedata[ST_CKSUM]));
      fr_r          <= fr_set_s  | (fr_r  & ~(sts_clr_s & writedata[ST_FRAME]));
      frame_count_r <= frame_count_r + (fc_inc_s ? FCNT_W'(1) : FCNT_W'(0));
      if (write && (address == ADDR_CTRL)) enable_r <= writedata[0];
      data_export_r <= status_s;
    end
  end

  // STATUS image assembled from live state
  always_comb begin
    status_s           = 32'h0;
    status_s[ST_EMPTY] = empty_s;
    status_s[ST_FULL]  = full_s;
    status_s[ST_OVF]   = ovf_r;
    status_s[ST_CKSUM] = ck_r;
    status_s[ST_FRAME] = fr_r;
    status_s[ST_BUSY]  = (state_r != IDLE);
    status_s[15:8]     = 8'(level_s);
    status_s[31:16]    = frame_count_r;
  end

`ifdef PROTO_RX_IRQ_EN
  logic [1:0] ie_r;
  logic       irq_r;

  // Interrupt enables and registered interrupt line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ie_r  <= 2'b00;
      irq_r <= 1'b0;
    end else begin
      if (write && (address == ADDR_CTRL)) ie_r <= writedata[3:2];
      irq_r <= (~empty_s & ie_r[0]) | ((ovf_r | ck_r | fr_r) & ie_r[1]);
    end
  end

  assign irq       = irq_r;
  assign ctrl_rd_s = {28'h0, ie_r, 1'b0, enable_r};
`else
  assign ctrl_rd_s = {31'h0, enable_r};
`endif

  // Zero-latency read mux; an empty DATA read returns zero
  always_comb begin
    readdata = 32'h0;
    if (read) begin
      case (address)
        ADDR_DATA:   readdata = empty_s ? 32'h0 : {8'h00, head_s};
        ADDR_STATUS: readdata = status_s;
        ADDR_CTRL:   readdata = ctrl_rd_s;
        default:     readdata = 32'h0;
      endcase
    end else begin
      readdata = 32'h0;
    end
  end

  assign data_export = data_export_r;

endmodule

// File: doc/protocol_receiver_interface.md
Name: protocol_receiver_interface

Overview:
- Avalon-MM slave peripheral; receive-side counterpart of the protocol sender interface.
- Watches the 32-bit protocol bus on `data_import` and deframes header/data/trailer words.
- Checks the frame checksum and buffers payload words in a FIFO for the CPU to pop via `read`/`readdata`.
- Status and control are exposed through a small register map.

Parameters:
- DEPTH, 16, payload FIFO entries; power of two, 2..128.
- LVL_W, $clog2(DEPTH)+1, FIFO level counter width.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
- write  in  1  Avalon write strobe.
- writedata  in  32  write data.
- read  in  1  Avalon read strobe.
- readdata  out  32  read data, valid in the same cycle as read (latency 0).
- data_import  in  32  protocol word from the remote sender, same clock domain.
- data_export  out  32  mirrors the STATUS register, for probing.

Behaviour:
- Reset (asynchronous, active-high): FSM to IDLE, FIFO empty, all flags 0, frame_count 0, enable 0, toggle register 0; readdata and data_export 0.
- Word format:
  - [31] toggle strobe; a new word is detected when data_import[31] differs from the stored toggle register. The register updates every cycle, even when disabled.
  - [30:29] type: 00 reserved, 01 HDR, 10 DAT, 11 TRL.
  - HDR: length in [7:0]. DAT: payload in [23:0]. TRL: checksum in [23:0].
- New words are processed only when CTRL.enable=1, one word per cycle, acted on in the cycle after detection.
- FSM transitions:
  - IDLE: HDR with len>0 → DATA (cnt=len, sum=0). HDR with len=0 → CHK. DAT or TRL → set framing_err, stay in IDLE.
  - DATA, on DAT: push payload to FIFO, sum=(sum+payload) mod 2^24, cnt−1; at cnt=1 → CHK.
  - DATA, on HDR: set framing_err, restart with the new header.
  - DATA, on TRL: set framing_err → IDLE.
  - CHK, on TRL: if checksum matches sum, frame_count+1 (16-bit, wraps); otherwise set cksum_err. Either way → IDLE.
  - CHK, on other types: set framing_err → IDLE.
  - Type 00: ignored in every state.
- FIFO full on push: the word is dropped and overflow is set; the checksum still includes the dropped word.
- Simultaneous push and pop: both happen, level unchanged. Pop on a full FIFO in the same cycle as a push: both succeed.
- DATA read (address 0): readdata = {8'h00, head}. The pop happens at the end of the read cycle. Reading an empty FIFO returns 0 and does not pop.
- STATUS read (address 1) returns:
  - [0] empty, [1] full, [2] overflow, [3] cksum_err, [4] framing_err.
  - [5] busy (FSM not in IDLE).
  - [15:8] level, zero-extended.
  - [31:16] frame_count.
- STATUS write: bits [4:2] are write-1-to-clear. If a set event and a clear land in the same cycle, the set wins.
- CTRL: [0] enable (read/write). [1] flush (write-only, self-clearing): empties the FIFO, returns the FSM to IDLE, resets cnt and sum; sticky flags are kept. Reads of CTRL return {31'b0, enable}.
- Address 3: reads return 0, writes are ignored.
- Clearing enable mid-frame freezes the FSM; processing resumes from the same state when enable returns to 1.

Optional Feature:
- Macro: PROTO_RX_IRQ_EN.
- When defined: adds port `irq` (out, 1). irq is registered and equals (!empty & CTRL[2]) | ((overflow|cksum_err|framing_err) & CTRL[3]). CTRL[3:2] are read/write interrupt enables, reset 0.
- When undefined: no irq port; CTRL[3:2] read as 0.

Decomposition:
- Package protocol_pkg holds:
  - type codes TYPE_RSV/HDR/DAT/TRL;
  - register addresses ADDR_DATA/STATUS/CTRL;
  - STATUS bit indices;
  - FSM state enum IDLE/DATA/CHK;
  - constants PAYLOAD_W=24 and FCNT_W=16.
- One sub-module: protocol_rx_fifo — synchronous FIFO with push, pop, head, level, full and empty; no protocol knowledge.

Test Plan:
- Enable; send HDR len=3, DAT 0x000001, 0x000002, 0x000003, TRL 0x000006 → STATUS level=3, frame_count=1, no errors; three DATA reads return 1, 2, 3, then empty=1.
- Same frame with TRL 0x000007 → cksum_err=1, payload still in FIFO; writing STATUS 0x08 clears cksum_err.
- DEPTH=16: send HDR len=20 with 20 DAT words, no reads → full=1, overflow=1, level=16, correct TRL still increments frame_count.
- DAT word in IDLE → framing_err=1. HDR len=2, one DAT, then HDR len=1, DAT 0x5, TRL 0x5 → framing_err stays set, frame_count=1, FIFO holds the first DAT and 0x5.
- Assert reset mid-frame (after HDR and one DAT) → all registers 0; the next complete frame is received correctly. Flush mid-frame gives the same FSM/FIFO result, and sticky flags are preserved.
- With PROTO_RX_IRQ_EN defined: CTRL=0x5, receive a one-word frame → irq=1; pop the word → irq=0 the next cycle.
